// File: rtl/water_reminder_timer.sv
// Drink-reminder timer: tracks consumed water from the filtered level, pulses on each
// drink, counts down a reminder interval per 1 Hz tick and flags a low bottle.
module water_reminder_timer #(
   parameter int LEVEL_W          = 4,
   parameter int TIMER_W          = 12,
   parameter int TOTAL_W          = 8,
   parameter int DEFAULT_INTERVAL = 1800,
   parameter int SNOOZE_TIME      = 300,
   parameter int REFILL_LEVEL     = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic [LEVEL_W-1:0] water_level,
   input  logic [TIMER_W-1:0] interval,
   input  logic               snooze,
   output logic               remind,
   output logic               refill,
   output logic [TIMER_W-1:0] timer,
   output logic [TOTAL_W-1:0] drank_total,
   output logic               drink_pulse
);

   typedef enum logic [1:0] {
      ST_INIT     = 2'd0,
      ST_COUNTING = 2'd1,
      ST_ALERT    = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [LEVEL_W-1:0] ref_q, ref_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [TOTAL_W-1:0] total_q, total_d;
   logic               remind_q, remind_d;
   logic               refill_q, refill_d;
   logic               pulse_q, pulse_d;

   logic [TIMER_W-1:0] reload;
   logic [LEVEL_W-1:0] drop;
   logic [TOTAL_W:0]   sum;
   logic [TOTAL_W-1:0] total_sat;
   logic               is_drink;
   logic               is_up;

   always_comb begin
      reload    = (interval != '0) ? interval : TIMER_W'(DEFAULT_INTERVAL);
      is_drink  = water_level < ref_q;
      is_up     = water_level > ref_q;
      drop      = ref_q - water_level;
      // The carry bit of the widened sum marks overflow past the accumulator maximum.
      sum       = {1'b0, total_q} + (TOTAL_W+1)'(drop);
      total_sat = sum[TOTAL_W] ? {TOTAL_W{1'b1}} : sum[TOTAL_W-1:0];
   end

   // NOTE: every next-state signal gets its default before the case, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      ref_d    = ref_q;
      timer_d  = timer_q;
      total_d  = total_q;
      remind_d = remind_q;
      pulse_d  = 1'b0;

      unique case (state_q)
         ST_INIT: begin
            ref_d    = water_level;
            timer_d  = reload;
            remind_d = 1'b0;
            state_d  = ST_COUNTING;
         end
         ST_COUNTING: begin
            if (is_drink) begin
               pulse_d = 1'b1;
               total_d = total_sat;
               ref_d   = water_level;
               timer_d = reload;
            end else begin
               if (is_up) ref_d = water_level;
               if (tick && timer_q > TIMER_W'(1)) begin
                  timer_d = timer_q - TIMER_W'(1);
               end else if (tick && timer_q == TIMER_W'(1)) begin
                  timer_d  = '0;
                  remind_d = 1'b1;
                  state_d  = ST_ALERT;
               end
            end
         end
         ST_ALERT: begin
            timer_d = '0;
            if (is_drink) begin
               pulse_d  = 1'b1;
               total_d  = total_sat;
               ref_d    = water_level;
               timer_d  = reload;
               remind_d = 1'b0;
               state_d  = ST_COUNTING;
            end else begin
               if (is_up) ref_d = water_level;
               if (snooze) begin
                  timer_d  = TIMER_W'(SNOOZE_TIME);
                  remind_d = 1'b0;
                  state_d  = ST_COUNTING;
               end
            end
         end
         default: begin
            state_d  = ST_INIT;
            remind_d = 1'b0;
         end
      endcase

      refill_d = ref_d <= LEVEL_W'(REFILL_LEVEL);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_INIT;
         ref_q    <= '0;
         timer_q  <= '0;
         total_q  <= '0;
         remind_q <= 1'b0;
         refill_q <= 1'b0;
         pulse_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ref_q    <= ref_d;
         timer_q  <= timer_d;
         total_q  <= total_d;
         remind_q <= remind_d;
         refill_q <= refill_d;
         pulse_q  <= pulse_d;
      end
   end

   assign remind      = remind_q;
   assign refill      = refill_q;
   assign timer       = timer_q;
   assign drank_total = total_q;
   assign drink_pulse = pulse_q;

endmodule

// File: doc/water_reminder_timer.md
Name: water_reminder_timer

Overview:
- Consumes the debounced 4-bit water level from the water-level filter FSM.
- Tracks how much water has been consumed and detects each drinking event.
- Raises a reminder when no drink occurs within a programmable number of seconds.
- Flags low-bottle (refill) and feeds the display/LED/buzzer stage downstream.

Parameters:
- LEVEL_W, 4: width of the water level input.
- TIMER_W, 12: width of the seconds countdown and of the interval input.
- TOTAL_W, 8: width of the saturating consumed-water accumulator.
- DEFAULT_INTERVAL, 1800: reload value in seconds used when interval input is 0.
- SNOOZE_TIME, 300: reload value in seconds applied on snooze.
- REFILL_LEVEL, 2: refill asserts when the level is at or below this value.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- tick, input, 1: one-clk-wide 1 Hz enable pulse from the prescaler.
- water_level, input, LEVEL_W: filtered, stable water level from the upstream filter FSM.
- interval, input, TIMER_W: reminder interval in seconds; sampled at each reload.
- snooze, input, 1: level-sampled request to defer an active reminder.
- remind, output, 1: high while a reminder is pending.
- refill, output, 1: high while the registered reference level is ≤ REFILL_LEVEL.
- timer, output, TIMER_W: seconds remaining until the reminder.
- drank_total, output, TOTAL_W: cumulative level units consumed, saturating.
- drink_pulse, output, 1: one-clk pulse per detected drink.

Behaviour:
- All outputs are registered.
- Reset (reset=0, async) clears:
  - state to INIT;
  - ref_level, timer, drank_total to 0;
  - remind, refill, drink_pulse to 0.
- Reload value = interval when interval≠0, otherwise DEFAULT_INTERVAL.
- State INIT:
  - first edge after reset release captures ref_level←water_level and timer←reload;
  - no drink is evaluated; state→COUNTING.
- State COUNTING, priority highest first:
  1. Drink: water_level<ref_level.
     - drink_pulse=1 for exactly one cycle.
     - drank_total += ref_level−water_level, saturating at 2^TOTAL_W−1.
     - ref_level←water_level; timer←reload.
  2. Refill-up: water_level>ref_level.
     - ref_level←water_level; no pulse; drank_total and timer unchanged.
     - The timer still decrements on tick this cycle.
  3. Countdown: tick with timer>1 → timer−1; tick with timer==1 → timer←0, remind←1, state→ALERT.
- State ALERT:
  - timer holds 0; tick is ignored; remind stays 1.
  - Drink (as above) → remind←0, timer←reload, state→COUNTING.
  - snooze with no drink → remind←0, timer←SNOOZE_TIME, state→COUNTING.
  - Refill-up updates ref_level and stays in ALERT.
- Simultaneous events:
  - drink beats tick (reload, no decrement, no alert);
  - drink beats snooze;
  - snooze in COUNTING is ignored.
- refill is recomputed every cycle from the updated ref_level, in every state except INIT, where it comes from the captured level.
- Latency: a level change at cycle N is reflected on drink_pulse, drank_total and timer at edge N+1.
- interval changes take effect only at the next reload.
- Reset asserted mid-operation clears everything immediately, without waiting for clk; the block restarts in INIT.
- No other states exist. Unreachable encodings recover to INIT.

Test Plan:
- Reset/init:
  - reset=0 → all outputs 0.
  - Release with water_level=15, interval=5 → one edge later timer=5, remind=0, refill=0.
- Countdown to alert:
  - level held 15, 5 tick pulses → timer 4,3,2,1,0; remind=1 after the 5th tick.
  - 3 further ticks → timer=0, remind=1.
- Drink clears alert:
  - in ALERT, level 15→12 → drink_pulse high one cycle, drank_total=3, remind=0, timer=5.
- Refill and low level:
  - level 12→15 → no pulse, drank_total=3, timer keeps counting.
  - Level 15→2 → drank_total=16, refill=1.
  - Level 2→15 → refill=0.
- Simultaneous and snooze:
  - tick and drink in the same cycle at timer=1 → no alert, timer=5.
  - In ALERT, snooze=1 with SNOOZE_TIME=3 → remind=0, timer=3.
  - interval=0 at reload → timer=1800.
- Saturation and async reset:
  - drank_total=250 then a 13-unit drop → 255.
  - reset pulsed low between clk edges mid-count → outputs 0 before the next edge; INIT recapture follows.
